// File: rtl/serial_frame_rx.sv
// -----------------------------------------------------------------------------
// serial_frame_rx
//
// Assembles framed words from a 1-bit serial stream, one bit per enabled
// clock. A frame is a start bit (0), DATA_W data bits sent LSB first, and a
// stop bit (1). The line idles high. A completed word is held in an output
// register and offered on a valid/ready port.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   din         serial bit, already registered by the capture flop
//   bit_en      qualifies din; a bit is consumed only when bit_en = 1
//   dout        received word, stable while dout_valid = 1
//   dout_valid  a word is available
//   dout_ready  consumer accepts the word on an edge with dout_valid = 1
//   frame_err   one-cycle pulse: the stop bit was sampled as 0
//   overrun     one-cycle pulse: a completed word was dropped because the
//               holding register was full and not being emptied
// -----------------------------------------------------------------------------
module serial_frame_rx #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              din,
   input  logic              bit_en,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic              frame_err,
   output logic              overrun
);

   // Wide enough to hold DATA_W itself, so the counter never wraps in a frame.
   localparam int CNT_W = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_STOP
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   sh_q, sh_d;
   logic [DATA_W-1:0]   dout_q, dout_d;
   logic                valid_q, valid_d;
   logic                ferr_q, ferr_d;
   logic                ovr_q, ovr_d;

   // High for the one edge on which a good stop bit is consumed.
   logic                word_done;

   // --------------------------------------------------------------------------
   // State registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge value of every other register.
      if (rst) begin
         // NOTE: the shift register is a handful of flops, not a RAM, so it is
         // cleared with everything else to give a fully defined reset state.
         state_q <= S_IDLE;
         cnt_q   <= '0;
         sh_q    <= '0;
         dout_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
      end
   end

   // --------------------------------------------------------------------------
   // Next-state logic: frame FSM plus output holding register
   // --------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // through the block can leave one unassigned and infer a latch.
      state_d   = state_q;
      cnt_d     = cnt_q;
      sh_d      = sh_q;
      dout_d    = dout_q;
      valid_d   = valid_q;
      ferr_d    = 1'b0;
      ovr_d     = 1'b0;
      word_done = 1'b0;

      // Disabled edges leave the frame machinery untouched.
      if (bit_en) begin
         case (state_q)
            S_IDLE: begin
               if (!din) begin
                  state_d = S_DATA;
                  cnt_d   = '0;
               end
            end
            S_DATA: begin
               // Compare-per-bit rather than a variable index keeps the index
               // width independent of DATA_W.
               for (int i = 0; i < DATA_W; i++) begin
                  if (cnt_q == CNT_W'(i)) sh_d[i] = din;
               end
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(DATA_W - 1)) state_d = S_STOP;
            end
            S_STOP: begin
               state_d = S_IDLE;
               if (din) word_done = 1'b1;
               else     ferr_d    = 1'b1;
            end
            default: state_d = S_IDLE;
         endcase
      end

      // A handshake empties the register; a word completing on the same edge
      // refills it, so valid stays high across a back-to-back hand-off.
      if (valid_q && dout_ready) valid_d = 1'b0;

      if (word_done) begin
         if (!valid_q || dout_ready) begin
            dout_d  = sh_q;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end
   end

   assign dout       = dout_q;
   assign dout_valid = valid_q;
   assign frame_err  = ferr_q;
   assign overrun    = ovr_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_serial_frame_rx
//
// Directed scenarios for the serial frame receiver followed by a randomized
// run checked against a frame-level reference model. Inputs change 1 ns after
// each rising edge and outputs are sampled at that same point, so every sample
// reflects the edge just taken.
// -----------------------------------------------------------------------------
module tb_serial_frame_rx;

   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          din;
   logic          bit_en;
   logic [DW-1:0] dout;
   logic          dout_valid;
   logic          dout_ready;
   logic          frame_err;
   logic          overrun;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   serial_frame_rx #(.DATA_W(DW)) dut (
      .clk        (clk),
      .rst        (rst),
      .din        (din),
      .bit_en     (bit_en),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .frame_err  (frame_err),
      .overrun    (overrun)
   );

   // ---------------------------------------------------------------------------
   // Stimulus helpers (drive only, no checking)
   // ---------------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic b, input logic en);
      din    = b;
      bit_en = en;
      tick();
   endtask

   // Start bit plus data bits, all enabled; the caller sends the stop bit.
   task automatic send_bits(input logic [DW-1:0] d);
      drive(1'b0, 1'b1);
      for (int i = 0; i < DW; i++) drive(d[i], 1'b1);
   endtask

   // Idle line with the consumer ready, so any held word drains.
   task automatic drain();
      dout_ready = 1'b1;
      drive(1'b1, 1'b1);
      drive(1'b1, 1'b1);
   endtask

   // ---------------------------------------------------------------------------
   // Scenarios
   // ---------------------------------------------------------------------------
   task automatic test_reset();
      rst = 1'b1; din = 1'b1; bit_en = 1'b1; dout_ready = 1'b0;
      tick();
      tick();
      tests_run++; if (dout_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got=%b exp=0", dout_valid); end
      tests_run++; if (dout !== '0) begin tests_failed++; $display("FAIL reset_dout got=%h exp=00", dout); end
      tests_run++; if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL reset_ferr got=%b exp=0", frame_err); end
      tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL reset_ovr got=%b exp=0", overrun); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      dout_ready = 1'b1;
      send_bits(8'hA5);
      tests_run++; if (dout_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_early got=%b exp=0", dout_valid); end
      drive(1'b1, 1'b1);   // stop bit, 10th cycle after the start bit
      tests_run++; if (dout_valid !== 1'b1) begin tests_failed++; $display("FAIL basic_valid got=%b exp=1", dout_valid); end
      tests_run++; if (dout !== 8'hA5) begin tests_failed++; $display("FAIL basic_dout got=%h exp=a5", dout); end
      tests_run++; if ({frame_err, overrun} !== 2'b00) begin tests_failed++; $display("FAIL basic_flags got=%b exp=00", {frame_err, overrun}); end
      drive(1'b1, 1'b1);
      tests_run++; if (dout_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_one_cycle got=%b exp=0", dout_valid); end
   endtask

   task automatic test_bit_en_toggle();
      logic [DW+1:0] fr;
      fr = {1'b1, 8'h3C, 1'b0};
      dout_ready = 1'b1;
      for (int i = 0; i < DW + 2; i++) begin
         drive(fr[i], 1'b1);
         if (i == DW + 1) begin
            tests_run++; if (dout_valid !== 1'b1) begin tests_failed++; $display("FAIL toggle_valid got=%b exp=1", dout_valid); end
            tests_run++; if (dout !== 8'h3C) begin tests_failed++; $display("FAIL toggle_dout got=%h exp=3c", dout); end
         end
         // Garbage on the line during disabled cycles must be ignored.
         drive(1'($urandom_range(0, 1)), 1'b0);
         if (i == DW) begin
            tests_run++; if (dout_valid !== 1'b0) begin tests_failed++; $display("FAIL toggle_early got=%b exp=0", dout_valid); end
         end
      end
      tests_run++; if (dout_valid !== 1'b0) begin tests_failed++; $display("FAIL toggle_drop got=%b exp=0", dout_valid); end
      drain();
   endtask

   task automatic test_frame_err();
      int pulses;
      drain();
      send_bits(8'h5A);
      drive(1'b0, 1'b1);   // bad stop bit
      tests_run++; if (frame_err !== 1'b1) begin tests_failed++; $display("FAIL ferr_pulse got=%b exp=1", frame_err); end
      tests_run++; if (dout_valid !== 1'b0) begin tests_failed++; $display("FAIL ferr_valid got=%b exp=0", dout_valid); end
      tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL ferr_ovr got=%b exp=0", overrun); end
      drive(1'b1, 1'b1);
      tests_run++; if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL ferr_once got=%b exp=0", frame_err); end
      send_bits(8'h81);
      drive(1'b1, 1'b1);
      tests_run++; if ({dout_valid, dout} !== {1'b1, 8'h81}) begin tests_failed++; $display("FAIL ferr_recover got=%b/%h exp=1/81", dout_valid, dout); end
      drain();
      // Continuous-low line: one error per DW+2 enabled bits.
      pulses = 0;
      for (int i = 0; i < 2 * (DW + 2); i++) begin
         drive(1'b0, 1'b1);
         if (frame_err === 1'b1) pulses++;
      end
      tests_run++; if (pulses != 2) begin tests_failed++; $display("FAIL ferr_low_line got=%0d exp=2", pulses); end
      tests_run++; if (dout_valid !== 1'b0) begin tests_failed++; $display("FAIL ferr_low_valid got=%b exp=0", dout_valid); end
      drain();
   endtask

   task automatic test_overrun();
      drain();
      dout_ready = 1'b0;
      send_bits(8'h11);
      drive(1'b1, 1'b1);
      tests_run++; if ({dout_valid, dout, overrun} !== {1'b1, 8'h11, 1'b0}) begin tests_failed++; $display("FAIL ovr_first got=%b/%h/%b exp=1/11/0", dout_valid, dout, overrun); end
      send_bits(8'h22);    // back-to-back start bit
      drive(1'b1, 1'b1);
      tests_run++; if (overrun !== 1'b1) begin tests_failed++; $display("FAIL ovr_pulse got=%b exp=1", overrun); end
      tests_run++; if ({dout_valid, dout} !== {1'b1, 8'h11}) begin tests_failed++; $display("FAIL ovr_hold got=%b/%h exp=1/11", dout_valid, dout); end
      tests_run++; if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL ovr_ferr got=%b exp=0", frame_err); end
      dout_ready = 1'b1;
      drive(1'b1, 1'b1);
      tests_run++; if ({dout_valid, overrun} !== 2'b00) begin tests_failed++; $display("FAIL ovr_transfer got=%b/%b exp=0/0", dout_valid, overrun); end
   endtask

   task automatic test_back_to_back();
      drain();
      dout_ready = 1'b0;
      send_bits(8'h33);
      drive(1'b1, 1'b1);
      tests_run++; if ({dout_valid, dout} !== {1'b1, 8'h33}) begin tests_failed++; $display("FAIL b2b_first got=%b/%h exp=1/33", dout_valid, dout); end
      send_bits(8'h44);
      dout_ready = 1'b1;   // accept exactly on the completion edge
      drive(1'b1, 1'b1);
      tests_run++; if ({dout_valid, dout} !== {1'b1, 8'h44}) begin tests_failed++; $display("FAIL b2b_second got=%b/%h exp=1/44", dout_valid, dout); end
      tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL b2b_ovr got=%b exp=0", overrun); end
      drive(1'b1, 1'b1);
      tests_run++; if (dout_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_drain got=%b exp=0", dout_valid); end
   endtask

   task automatic test_reset_mid();
      int flags;
      drain();
      dout_ready = 1'b0;
      send_bits(8'h99);
      drive(1'b1, 1'b1);   // leave 0x99 held so reset has something to clear
      drive(1'b0, 1'b1);   // start
      for (int i = 0; i < 4; i++) drive(1'b0, 1'b1);
      rst = 1'b1;
      drive(1'b1, 1'b1);   // data bit 4 coincides with reset
      rst = 1'b0;
      tests_run++; if ({dout_valid, dout, frame_err, overrun} !== '0) begin tests_failed++; $display("FAIL rst_mid got=%b/%h/%b/%b exp=0/00/0/0", dout_valid, dout, frame_err, overrun); end
      // The rest of the aborted frame (all ones) must look like idle line.
      flags = 0;
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 1'b1);
         if (dout_valid || frame_err || overrun) flags++;
      end
      tests_run++; if (flags != 0) begin tests_failed++; $display("FAIL rst_abort got=%0d exp=0", flags); end
      dout_ready = 1'b1;
      send_bits(8'hF0);
      drive(1'b1, 1'b1);
      tests_run++; if ({dout_valid, dout} !== {1'b1, 8'hF0}) begin tests_failed++; $display("FAIL rst_fresh got=%b/%h exp=1/f0", dout_valid, dout); end
      drain();
   endtask

   // ---------------------------------------------------------------------------
   // Randomized frames against a frame-level model
   // ---------------------------------------------------------------------------
   typedef struct {
      logic          b;
      bit            is_stop;
      logic [DW-1:0] word;
   } line_bit_t;

   task automatic test_random();
      line_bit_t     q[$];
      line_bit_t     e;
      logic [DW-1:0] w;
      logic          en, r, m_valid, exp_f, exp_o;
      logic [DW-1:0] m_data;
      int            errs_before;

      for (int f = 0; f < 250; f++) begin
         w = DW'($urandom);
         for (int k = $urandom_range(0, 2); k > 0; k--) q.push_back('{1'b1, 1'b0, '0});
         q.push_back('{1'b0, 1'b0, '0});
         for (int i = 0; i < DW; i++) q.push_back('{w[i], 1'b0, '0});
         q.push_back('{($urandom_range(0, 7) != 0), 1'b1, w});
      end

      drain();
      m_valid = 1'b0;
      m_data  = '0;
      errs_before = tests_failed;
      while (q.size() > 0) begin
         en = ($urandom_range(0, 3) != 0);
         r  = 1'($urandom_range(0, 1));
         e  = '{1'b1, 1'b0, '0};
         if (en) e = q.pop_front();
         din        = en ? e.b : 1'($urandom_range(0, 1));
         bit_en     = en;
         dout_ready = r;

         // Expected outcome of this edge, from the framing/handshake rules.
         exp_f = en && e.is_stop && !e.b;
         exp_o = 1'b0;
         if (en && e.is_stop && e.b) begin
            if (!m_valid || r) begin
               m_valid = 1'b1;
               m_data  = e.word;
            end else begin
               exp_o = 1'b1;
            end
         end else if (m_valid && r) begin
            m_valid = 1'b0;
         end

         tick();
         tests_run++;
         if (dout_valid !== m_valid || frame_err !== exp_f || overrun !== exp_o ||
             (m_valid && dout !== m_data)) begin
            tests_failed++;
            if (tests_failed - errs_before <= 10)
               $display("FAIL rand_cycle got=%b/%h/%b/%b exp=%b/%h/%b/%b",
                        dout_valid, dout, frame_err, overrun, m_valid, m_data, exp_f, exp_o);
         end
      end
      drain();
   endtask

   // ---------------------------------------------------------------------------
   // Sequence
   // ---------------------------------------------------------------------------
   initial begin
      rst = 1'b1; din = 1'b1; bit_en = 1'b0; dout_ready = 1'b0;
      test_reset();
      test_basic();
      test_bit_en_toggle();
      test_frame_err();
      test_overrun();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "simulation time limit reached");
   end

endmodule

// File: doc/serial_frame_rx.md
# serial_frame_rx

Receives the 1-bit serial stream produced by the `dff` capture stage, one bit per enabled clock, and assembles framed words: start bit (0), `DATA_W` data bits LSB first, stop bit (1). Completed words are presented on a valid/ready output port to the downstream consumer. Stop-bit violations and words arriving while the output is still occupied are flagged. The line idles high.

## Interface

Parameters:
- `DATA_W`, default 8: data bits per frame; legal range 1–32.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `din`  in  1  serial bit, the registered `dout` of the capture flop.
- `bit_en`  in  1  qualifies `din`; a bit is consumed only on edges where `bit_en` = 1.
- `dout`  out  `DATA_W`  received word, stable while `dout_valid` = 1.
- `dout_valid`  out  1  word available.
- `dout_ready`  in  1  consumer accepts the word.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled as 0.
- `overrun`  out  1  one-cycle pulse: a completed word was dropped.

## Operation

- State machine:
  - IDLE: waits for `bit_en` & `din` = 0, then enters DATA with the bit counter at 0.
  - DATA: each enabled bit is shifted into `sh[cnt]` and `cnt` increments. After bit `DATA_W`-1, go to STOP.
  - STOP: the enabled bit decides the outcome.
    - 1: word completes, go to IDLE.
    - 0: `frame_err` pulses, the word is discarded, go to IDLE.
- Edges with `bit_en` = 0 change no state, counter or shift register.
- `cnt` width is `$clog2(DATA_W+1)`; no wrap occurs inside a frame.
- Output holding register:
  - On word completion with the register empty, or being emptied on the same edge: `dout` <= `sh`, `dout_valid` <= 1.
  - On word completion with `dout_valid` = 1 and `dout_ready` = 0: the new word is dropped, `dout` is unchanged, and `overrun` pulses.
  - Handshake: transfer occurs on an edge with `dout_valid` & `dout_ready`. `dout_valid` then clears unless a new word completes on that same edge.
  - `dout_ready` while `dout_valid` = 0 has no effect.
- After a frame error, IDLE re-arms immediately. A continuous-low line therefore yields one `frame_err` every `DATA_W`+2 enabled bits.
- Frame error and overrun are mutually exclusive in a cycle; an errored frame never causes an overrun.
- Reset:
  - State goes to IDLE and `cnt`, `sh` and `dout` go to 0.
  - `dout_valid`, `frame_err` and `overrun` go to 0.
  - A reset mid-frame aborts the frame with no flags.
  - `rst` has priority over every other event on the same edge.

## Timing

- All outputs are registered; no combinational path from input to output.
- With `bit_en` held 1, let the start bit be present in cycle 0:
  - Data bits occupy cycles 1..`DATA_W`; the stop bit is in cycle `DATA_W`+1.
  - `dout_valid` rises in cycle `DATA_W`+2. `frame_err` or `overrun` would occupy that same cycle.
- Back-to-back frames: the next start bit may be in cycle `DATA_W`+2. Sustained throughput is one word per `DATA_W`+2 enabled bits.
- `dout_valid` falls on the edge after the cycle in which `dout_ready` = 1.
- `dout` must not change while `dout_valid` = 1 except on an accepting edge.
- Minimum reset assertion is one `clk` edge. Outputs read 0 from the cycle after that edge.

## Test plan

- Reset, then `DATA_W`=8, `bit_en`=1, `dout_ready`=1, send frame 0x A5:
  - Bits 0,1,0,1,0,0,1,0,1,1.
  - `dout_valid`=1 with `dout`=0xA5 exactly 10 cycles after the start bit, for one cycle. No flags.
- `bit_en` toggling 1,0,1,0… during frame 0x3C: the same result, delivered after 20 cycles. Disabled cycles must not shift the register.
- Frame 0x5A with stop bit 0: `frame_err` pulses once in cycle 10 and `dout_valid` stays 0. The next correct frame 0x81 is delivered normally.
- `dout_ready`=0, frames 0x11 then 0x22 sent back-to-back:
  - `dout`=0x11 is held and `overrun` pulses at completion of 0x22.
  - Raising `dout_ready` transfers 0x11, then `dout_valid`=0.
- `dout_ready` asserted on the exact edge frame 0x44 completes while 0x33 is held: 0x33 transfers, `dout`=0x44 with `dout_valid` remaining 1, and no `overrun`.
- `rst` pulsed at data bit 4 of a frame: all outputs 0 next cycle and no flags. A fresh frame 0xF0 afterwards is received correctly.
